// File: rtl/hub75_scan_scheduler.sv
// rtl/hub75_scan_scheduler.sv - HUB75 row/latch/OE sequencer with BCM planes
// Shifts the next (row, plane) through the shift engine while the current plane is lit.
module hub75_scan_scheduler #(
   parameter int SCAN_RATE      = 32,
   parameter int BIT_PLANES     = 3,
   parameter int BASE_OE_CYCLES = 8,
   parameter int BLANK_CYCLES   = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          enable,
   input  logic                          shift_done,
   output logic                          shift_start,
   output logic [$clog2(SCAN_RATE)-1:0]  shift_row,
   output logic [$clog2(BIT_PLANES)-1:0] shift_plane,
   output logic [$clog2(SCAN_RATE)-1:0]  hub75_addr,
   output logic                          hub75_latch,
   output logic                          hub75_oe,
   output logic                          frame_done,
   output logic                          busy
);
   localparam int RW = $clog2(SCAN_RATE);
   localparam int PW = $clog2(BIT_PLANES);
   localparam int CW = $clog2(BASE_OE_CYCLES << (BIT_PLANES - 1)) + 1;
   localparam logic [RW-1:0] ROW_LAST   = RW'(SCAN_RATE - 1);
   localparam logic [PW-1:0] PLANE_LAST = PW'(BIT_PLANES - 1);
   localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_BLANK, S_LATCH, S_DISPLAY} state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] srow, srow_nxt, drow, drow_nxt, adv_row;
   logic [PW-1:0] splane, splane_nxt, dplane, dplane_nxt, adv_plane;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          pending, pending_nxt, shifted, shifted_nxt;
   logic          shift_start_nxt, latch_nxt, oe_nxt, frame_done_nxt;
   logic [RW-1:0] shift_row_nxt, addr_nxt;
   logic [PW-1:0] shift_plane_nxt;
   logic          sd_valid;

   // A done pulse coincident with our own start pulse cannot belong to that request.
   assign sd_valid = shift_done & ~shift_start;

   always_comb begin
      adv_plane = splane + 1'b1;
      adv_row   = srow;
      if (splane == PLANE_LAST) begin
         adv_plane = '0;
         adv_row   = (srow == ROW_LAST) ? '0 : srow + 1'b1;
      end
   end

   always_comb begin
      state_nxt       = state;
      srow_nxt        = srow;
      splane_nxt      = splane;
      drow_nxt        = drow;
      dplane_nxt      = dplane;
      cnt_nxt         = cnt;
      pending_nxt     = pending;
      shifted_nxt     = shifted;
      shift_start_nxt = 1'b0;
      shift_row_nxt   = shift_row;
      shift_plane_nxt = shift_plane;
      addr_nxt        = hub75_addr;
      latch_nxt       = 1'b0;
      oe_nxt          = 1'b1;
      frame_done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) begin
               state_nxt       = S_PRIME;
               srow_nxt        = '0;
               splane_nxt      = '0;
               shift_start_nxt = 1'b1;
               shift_row_nxt   = '0;
               shift_plane_nxt = '0;
            end
         end
         S_PRIME: begin
            if (sd_valid) begin
               state_nxt = S_BLANK;
               cnt_nxt   = BLANK_LOAD;
            end
         end
         S_BLANK: begin
            if (cnt == BLANK_LOAD) addr_nxt = srow;
            if (cnt == '0) begin
               state_nxt = S_LATCH;
               latch_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_LATCH: begin
            state_nxt   = S_DISPLAY;
            drow_nxt    = srow;
            dplane_nxt  = splane;
            oe_nxt      = 1'b0;
            cnt_nxt     = CW'(BASE_OE_CYCLES) << splane;
            shifted_nxt = 1'b0;
            pending_nxt = enable;
            if (enable) begin
               srow_nxt        = adv_row;
               splane_nxt      = adv_plane;
               shift_start_nxt = 1'b1;
               shift_row_nxt   = adv_row;
               shift_plane_nxt = adv_plane;
            end
         end
         S_DISPLAY: begin
            if (sd_valid) shifted_nxt = 1'b1;
            if (cnt > CW'(1)) begin
               cnt_nxt = cnt - 1'b1;
               oe_nxt  = 1'b0;
            end else begin
               // Plane time is spent; hold blanked until the next plane is shifted.
               cnt_nxt = '0;
               if (shifted || sd_valid || !pending) begin
                  frame_done_nxt = (drow == ROW_LAST) && (dplane == PLANE_LAST);
                  if (pending) begin
                     state_nxt = S_BLANK;
                     cnt_nxt   = BLANK_LOAD;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= S_IDLE;
         srow        <= '0;
         splane      <= '0;
         drow        <= '0;
         dplane      <= '0;
         cnt         <= '0;
         pending     <= 1'b0;
         shifted     <= 1'b0;
         shift_start <= 1'b0;
         shift_row   <= '0;
         shift_plane <= '0;
         hub75_addr  <= '0;
         hub75_latch <= 1'b0;
         hub75_oe    <= 1'b1;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         srow        <= srow_nxt;
         splane      <= splane_nxt;
         drow        <= drow_nxt;
         dplane      <= dplane_nxt;
         cnt         <= cnt_nxt;
         pending     <= pending_nxt;
         shifted     <= shifted_nxt;
         shift_start <= shift_start_nxt;
         shift_row   <= shift_row_nxt;
         shift_plane <= shift_plane_nxt;
         hub75_addr  <= addr_nxt;
         hub75_latch <= latch_nxt;
         hub75_oe    <= oe_nxt;
         frame_done  <= frame_done_nxt;
         busy        <= (state_nxt != S_IDLE);
      end
   end
endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// tb/tb_hub75_scan_scheduler.sv - scoreboard bench for hub75_scan_scheduler
module tb_hub75_scan_scheduler;
   localparam int BLK = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       eng_done = 1'b0;
   logic       stray_done = 1'b0;
   logic       shift_start, hub75_latch, hub75_oe, frame_done, busy;
   logic [4:0] shift_row, hub75_addr;
   logic [1:0] shift_plane;

   always #5 clk = ~clk;

   hub75_scan_scheduler dut (
      .clk_in      (clk),
      .rst_in      (rst),
      .enable      (enable),
      .shift_done  (eng_done | stray_done),
      .shift_start (shift_start),
      .shift_row   (shift_row),
      .shift_plane (shift_plane),
      .hub75_addr  (hub75_addr),
      .hub75_latch (hub75_latch),
      .hub75_oe    (hub75_oe),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   typedef struct {
      int row;
      int plane;
      int gap;
   } disp_t;

   disp_t exp_disp[$];
   int    exp_srow[$];
   int    exp_splane[$];
   int    lat_q[$];

   int total = 0;
   int bad = 0;
   int m_row, m_plane, prev_len;
   bit m_first;

   task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic fresh();
      m_row = 0;
      m_plane = 0;
      m_first = 1;
   endtask

   task automatic push_shift_only(input int lat);
      exp_srow.push_back(m_row);
      exp_splane.push_back(m_plane);
      lat_q.push_back(lat);
   endtask

   // lat is the shift latency of this display's plane; the blanked gap before its
   // latch depends on that latency against the previous plane's OE time.
   task automatic push_disp(input int lat);
      disp_t d;
      d.row   = m_row;
      d.plane = m_plane;
      d.gap   = m_first ? -1 : ((lat < prev_len) ? BLK : lat - prev_len + 1 + BLK);
      exp_disp.push_back(d);
      push_shift_only(lat);
      prev_len = 8 << m_plane;
      m_first  = 0;
      if (m_plane == 2) begin
         m_plane = 0;
         m_row   = (m_row == 31) ? 0 : m_row + 1;
      end else begin
         m_plane++;
      end
   endtask

   // Shift engine: shift_done lands lat cycles after the start pulse.
   int cd = 0;
   always @(negedge clk) begin
      eng_done = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) eng_done = 1'b1;
      end
      if (shift_start === 1'b1) begin
         if (lat_q.size() > 0) cd = lat_q.pop_front();
         else cd = 4;
      end
   end

   int         lat_seen = 0;
   int         frames = 0;
   bit         tracking = 0;
   bit         gap_valid = 0;
   int         run_len, cur_row, cur_plane, gap_cnt;
   int         last_row = -1;
   int         last_plane = -1;
   logic [4:0] prev_addr = '0;
   logic       prev_oe = 1'b1;
   logic       prev_rst = 1'b1;

   always @(negedge clk) begin
      disp_t d;
      if (shift_start === 1'b1) begin
         if (exp_srow.size() == 0) check(shift_start, 0, "unexpected_shift_start");
         else begin
            check(shift_row, exp_srow.pop_front(), "shift_row");
            check(shift_plane, exp_splane.pop_front(), "shift_plane");
         end
      end
      if (hub75_latch === 1'b1) begin
         check(hub75_oe, 1, "oe_high_during_latch");
         if (exp_disp.size() == 0) check(hub75_latch, 0, "unexpected_latch");
         else begin
            d = exp_disp.pop_front();
            check(hub75_addr, d.row, "latch_addr");
            if (d.gap >= 0 && gap_valid) check(gap_cnt, d.gap, "blank_gap");
            tracking  = 1;
            run_len   = 0;
            cur_row   = d.row;
            cur_plane = d.plane;
            gap_valid = 0;
            lat_seen++;
         end
      end else if (tracking) begin
         if (hub75_oe === 1'b0) run_len++;
         else begin
            check(run_len, 8 << cur_plane, "oe_low_run");
            tracking   = 0;
            gap_valid  = 1;
            gap_cnt    = 1;
            last_row   = cur_row;
            last_plane = cur_plane;
         end
      end else if (gap_valid) begin
         gap_cnt++;
      end
      if (frame_done === 1'b1) begin
         frames++;
         check(last_row * 8 + last_plane, 31 * 8 + 2, "frame_done_position");
      end
      if (busy !== 1'b1 || rst) gap_valid = 0;
      if (rst) tracking = 0;
      if (hub75_addr !== prev_addr && !prev_rst) check(hub75_oe & prev_oe, 1, "addr_change_blanked");
      prev_addr = hub75_addr;
      prev_oe   = hub75_oe;
      prev_rst  = rst;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_latches(input int target, input int budget, input string tag);
      int n = 0;
      while (lat_seen < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(lat_seen >= target, 1, tag);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(busy, 0, tag);
   endtask

   task automatic wait_oe(input logic val, input int budget, input string tag);
      int n = 0;
      @(negedge clk);
      while (hub75_oe !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(hub75_oe, val, tag);
   endtask

   task automatic check_drained(input string tag);
      check(exp_disp.size(), 0, {tag, "_displays_left"});
      check(exp_srow.size(), 0, {tag, "_shifts_left"});
   endtask

   initial begin
      int base;
      int fbase;

      // reset values
      step(3);
      @(negedge clk);
      check(hub75_oe, 1, "rst_oe");
      check(hub75_latch, 0, "rst_latch");
      check(hub75_addr, 0, "rst_addr");
      check(busy, 0, "rst_busy");
      check(shift_start, 0, "rst_shift_start");
      check(frame_done, 0, "rst_frame_done");
      check(shift_row, 0, "rst_shift_row");
      check(shift_plane, 0, "rst_shift_plane");
      step(1);
      rst = 1'b0;
      step(2);

      // slow shift engine (64 cycles), rows 0..2, enable dropped during row 2 plane 1
      fresh();
      for (int i = 0; i < 9; i++) push_disp(64);
      base = lat_seen;
      enable = 1'b1;
      @(negedge clk);
      check(shift_start, 0, "start_not_early");
      @(negedge clk);
      check(shift_start, 1, "start_one_cycle_after_enable");
      check(busy, 1, "busy_after_start");
      wait_latches(base + 8, 3000, "slow_run_latches");
      step(3);
      enable = 1'b0;
      wait_idle(2000, "slow_run_idle");
      check(hub75_oe, 1, "slow_run_idle_oe");
      step(20);
      check_drained("slow_run");

      // plane 0 displayed while the next shift takes 100 cycles
      fresh();
      push_disp(4);
      push_disp(100);
      push_disp(4);
      base = lat_seen;
      step(1);
      enable = 1'b1;
      wait_latches(base + 2, 1000, "late_done_latches");
      step(3);
      enable = 1'b0;
      wait_idle(1000, "late_done_idle");
      check_drained("late_done");

      // shift_done coincident with OE expiry, plus a stray done pulse in BLANK
      fresh();
      push_disp(4);
      push_disp(7);
      push_disp(4);
      push_disp(31);
      base = lat_seen;
      step(1);
      enable = 1'b1;
      wait_latches(base + 2, 1000, "coincide_latches");
      wait_oe(1'b0, 100, "coincide_oe_on");
      wait_oe(1'b1, 100, "coincide_oe_off");
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      wait_latches(base + 3, 1000, "stray_latches");
      step(3);
      enable = 1'b0;
      wait_idle(1000, "coincide_idle");
      check_drained("coincide");

      // full frame with fast shifts; row wraps 31 -> 0 on the 97th display
      fresh();
      for (int i = 0; i < 97; i++) push_disp(4);
      base  = lat_seen;
      fbase = frames;
      step(1);
      enable = 1'b1;
      wait_latches(base + 96, 4000, "frame_latches");
      step(3);
      enable = 1'b0;
      wait_idle(1000, "frame_idle");
      check(frames - fbase, 1, "frame_done_count");
      check_drained("frame");

      // reset while displaying row 5 plane 2
      fresh();
      for (int i = 0; i < 18; i++) push_disp(4);
      push_shift_only(4);
      base = lat_seen;
      step(1);
      enable = 1'b1;
      wait_latches(base + 18, 1000, "reset_run_latches");
      step(6);
      check(hub75_oe, 0, "pre_reset_oe_on");
      rst = 1'b1;
      enable = 1'b0;
      step(1);
      rst = 1'b0;
      @(negedge clk);
      check(hub75_oe, 1, "midrst_oe");
      check(hub75_latch, 0, "midrst_latch");
      check(hub75_addr, 0, "midrst_addr");
      check(busy, 0, "midrst_busy");
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      step(10);
      check(busy, 0, "midrst_stays_idle");
      check_drained("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hub75_scan_scheduler.md
Name: hub75_scan_scheduler

Overview:
- Sequences the HUB75 panel refresh: row address, latch and output-enable, with binary-code-modulated (BCM) bit planes.
- Requests each (row, plane) column shift from the shift engine over a start/done handshake.
- Shifts the next plane while the current plane is displayed.
- Sits between frame_manager/hub75_output and the panel pins; replaces the free-running address logic in top_level.

Parameters:
SCAN_RATE, 32, number of row addresses (panel rows / 2)
BIT_PLANES, 3, bits per colour channel (RGB_RES / 3)
BASE_OE_CYCLES, 8, OE-on cycles for plane 0; plane p gets BASE_OE_CYCLES << p
BLANK_CYCLES, 2, OE-off cycles before each latch (address settle)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
enable  input  1  run refresh; sampled in IDLE and LATCH
shift_done  input  1  one-cycle pulse: shift engine finished clocking NUM_COLS pixels
shift_start  output  1  one-cycle pulse: begin shifting shift_row/shift_plane
shift_row  output  $clog2(SCAN_RATE)  row being shifted
shift_plane  output  $clog2(BIT_PLANES)  bit plane being shifted
hub75_addr  output  $clog2(SCAN_RATE)  panel row address
hub75_latch  output  1  panel latch, active high
hub75_oe  output  1  panel output enable, active low (1 = blanked)
frame_done  output  1  one-cycle pulse at end of last row/last plane display
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk_in; reset rst_in is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, shift_start=0, shift_row=0, shift_plane=0, hub75_addr=0, hub75_latch=0, hub75_oe=1, frame_done=0, busy=0.
- A reset asserted mid-operation forces these values on the next edge; any in-flight shift_done is discarded.
- Targets: shift target (srow, splane) and display target (drow, dplane).
- Advancing a target: plane increments; at BIT_PLANES-1 it wraps to 0 and row increments; row wraps SCAN_RATE-1 -> 0.
- IDLE: hub75_oe=1. If enable=1, the next cycle pulses shift_start with srow=0, splane=0 and enters PRIME.
- PRIME: wait for shift_done, then go to BLANK next cycle.
- BLANK: hub75_oe=1 for exactly BLANK_CYCLES cycles. hub75_addr <= srow on the first BLANK cycle.
- LATCH (1 cycle): hub75_latch=1, hub75_oe=1, drow/dplane <= srow/splane.
  - If enable=1: advance the shift target and set pending=1.
  - Else: pending=0.
- DISPLAY:
  - shift_start pulses on the first DISPLAY cycle iff pending=1.
  - hub75_oe=0 for exactly BASE_OE_CYCLES << dplane cycles, then hub75_oe=1.
  - shifted flag sets on shift_done, starting from the cycle after shift_start.
  - Exit when the OE counter has expired AND (shifted=1 or pending=0).
    - pending=1 -> BLANK.
    - pending=0 -> IDLE.
  - If the counter expires before shift_done, stay in DISPLAY with oe=1. Plane brightness stays exact; only the refresh rate degrades.
  - If shift_done and counter expiry coincide, exit on that same edge.
- frame_done pulses in the cycle after exiting a DISPLAY with drow=SCAN_RATE-1 and dplane=BIT_PLANES-1.
- shift_done received in IDLE, BLANK or LATCH, or a second pulse in DISPLAY, is ignored.
- Invariants:
  - hub75_latch and hub75_oe=0 are never high/low together.
  - hub75_addr changes only while hub75_oe=1 and at least 1 cycle before latch.
- Counter width: $clog2(BASE_OE_CYCLES << (BIT_PLANES-1)) + 1.

Test Plan:
- Reset mid-DISPLAY (plane 2, row 5), rst_in high 1 cycle -> next cycle hub75_oe=1, latch=0, addr=0, busy=0; a later shift_done produces no shift_start.
- enable=1 from IDLE, shift engine returns shift_done 64 cycles after each start -> first shift_start 1 cycle after enable; BLANK=2 cycles, latch 1 cycle; OE-low runs of 8/16/32 cycles for planes 0/1/2; addr 0,0,0,1,1,1…
- shift_done delayed to 100 cycles while displaying plane 0 -> oe low exactly 8 cycles, then high until shift_done; BLANK follows 1 cycle later.
- SCAN_RATE=4, BIT_PLANES=3, fast shift engine (done 4 cycles after start) -> frame_done pulses once per 12 displays; srow wraps 3->0; addr sequence repeats.
- Deassert enable during row 2 plane 1 DISPLAY, sampled at the next LATCH -> the row 2 plane 2 display completes (32 OE cycles), no further shift_start, IDLE with oe=1.
- shift_done arriving in the same cycle as OE counter expiry -> BLANK entered on the next edge with no extra wait cycle; a stray shift_done during BLANK -> ignored, timing unchanged.
